fetch_pipe_regs: RTL and testbench

- Consumer end of the load-use stall interface: holds the PC register and the IF/ID pipeline register.
- Honours the hazard detection unit's PC-write and IF/ID-write enables, and the branch flush from EX/MEM.
- Sits between instruction memory and the decode stage.
- Adds a consecutive-stall watchdog so verification can flag a deadlocked pipeline.

---
 rtl/fetch_pipe_regs.sv | 127 ++++++++++++
 tb/tb_fetch_pipe_regs.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_pipe_regs.sv
// PC register and IF/ID pipeline register with hazard-unit write enables, branch flush
// and a consecutive-stall watchdog. Optional perf counters under FETCH_PERF_CNT_EN.
module fetch_pipe_regs #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hzdPcWrite,
  input  logic        hzdIfIdWrite,
  input  logic        flush,
  input  logic [31:0] branchTarget,
  input  logic [31:0] instrIn,
  output logic [31:0] pc,
  output logic [31:0] ifIdInstr,
  output logic [31:0] ifIdPcPlus4,
  output logic        ifIdValid,
  output logic        stallStuck
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] stallCount,
  output logic [31:0] flushCount
`endif
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(255);
  localparam logic [CNT_W-1:0] STALL_LIM = CNT_W'(MAX_STALL);

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

  logic [XLEN-1:0]  pc_q, pc_d;
  if_id_t           if_id_q, if_id_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             stuck_q, stuck_d;
  logic [XLEN-1:0]  pc_plus4;
  logic             stall_cycle;

  assign pc_plus4    = pc_q + XLEN'(4);
  assign stall_cycle = !flush && !hzdIfIdWrite;

  // Next-state: flush beats the hazard enables; reset is applied in the register.
  always_comb begin
    pc_d        = pc_q;
    if_id_d     = if_id_q;
    stall_cnt_d = stall_cnt_q;
    if (flush) begin
      pc_d        = branchTarget;
      if_id_d     = IF_ID_BUBBLE;
      stall_cnt_d = '0;
    end else begin
      if (hzdPcWrite) begin
        pc_d = pc_plus4;
      end
      if (hzdIfIdWrite) begin
        if_id_d     = '{instr: instrIn, pc_plus4: pc_plus4, valid: 1'b1};
        stall_cnt_d = '0;
      end else if (stall_cnt_q != CNT_SAT) begin
        stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
    end
    // Registered flag tracks the counter value it will hold after this edge.
    stuck_d = (stall_cnt_d >= STALL_LIM);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q        <= RESET_PC;
      if_id_q     <= IF_ID_BUBBLE;
      stall_cnt_q <= '0;
      stuck_q     <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      if_id_q     <= if_id_d;
      stall_cnt_q <= stall_cnt_d;
      stuck_q     <= stuck_d;
    end
  end

  assign pc          = pc_q;
  assign ifIdInstr   = if_id_q.instr;
  assign ifIdPcPlus4 = if_id_q.pc_plus4;
  assign ifIdValid   = if_id_q.valid;
  assign stallStuck  = stuck_q;

`ifdef FETCH_PERF_CNT_EN
  logic [XLEN-1:0] stall_perf_q, stall_perf_d;
  logic [XLEN-1:0] flush_perf_q, flush_perf_d;

  // Free-running event counters, wrapping at 2^32.
  always_comb begin
    stall_perf_d = stall_perf_q;
    flush_perf_d = flush_perf_q;
    if (stall_cycle) begin
      stall_perf_d = stall_perf_q + XLEN'(1);
    end
    if (flush) begin
      flush_perf_d = flush_perf_q + XLEN'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_perf_q <= '0;
      flush_perf_q <= '0;
    end else begin
      stall_perf_q <= stall_perf_d;
      flush_perf_q <= flush_perf_d;
    end
  end

  assign stallCount = stall_perf_q;
  assign flushCount = flush_perf_q;
`else
  logic unused_stall_cycle;
  assign unused_stall_cycle = stall_cycle;
`endif

endmodule

// File: tb/tb_fetch_pipe_regs.sv
// Self-checking bench for fetch_pipe_regs: directed vector table, multi-cycle
// sequences, and randomized traffic against a behavioural model.
module tb_fetch_pipe_regs;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
  localparam int          MAX_STALL = 4;

  logic        clock = 1'b0;
  logic        reset, hzdPcWrite, hzdIfIdWrite, flush;
  logic [31:0] branchTarget, instrIn;
  logic [31:0] pc, ifIdInstr, ifIdPcPlus4;
  logic        ifIdValid, stallStuck;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stallCount, flushCount;
`endif

  int checks = 0;
  int errors = 0;

  fetch_pipe_regs #(
    .RESET_PC (RESET_PC),
    .NOP_INSTR(NOP_INSTR),
    .MAX_STALL(MAX_STALL)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .hzdPcWrite  (hzdPcWrite),
    .hzdIfIdWrite(hzdIfIdWrite),
    .flush       (flush),
    .branchTarget(branchTarget),
    .instrIn     (instrIn),
    .pc          (pc),
    .ifIdInstr   (ifIdInstr),
    .ifIdPcPlus4 (ifIdPcPlus4),
    .ifIdValid   (ifIdValid),
    .stallStuck  (stallStuck)
`ifdef FETCH_PERF_CNT_EN
    ,
    .stallCount  (stallCount),
    .flushCount  (flushCount)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        rst, pcw, ifw, fl;
    logic [31:0] tgt, instr;
    logic [31:0] e_pc, e_instr, e_pc4;
    logic        e_valid, e_stuck;
  } vec_t;

  // Behavioural model state.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  int          m_run;
  logic [31:0] m_stalls, m_flushes;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_cycle(input logic rst, input logic pcw, input logic ifw,
                             input logic fl, input logic [31:0] tgt, input logic [31:0] ins);
    @(negedge clock);
    reset = rst; hzdPcWrite = pcw; hzdIfIdWrite = ifw; flush = fl;
    branchTarget = tgt; instrIn = ins;
    @(posedge clock);
    #1;
  endtask

  // Model step: what a fetch stage should hold after one clock edge.
  task automatic model_step(input logic rst, input logic pcw, input logic ifw,
                            input logic fl, input logic [31:0] tgt, input logic [31:0] ins);
    logic [31:0] next_seq;
    next_seq = m_pc + 32'd4;
    if (rst) begin
      m_pc = RESET_PC; m_instr = NOP_INSTR; m_pc4 = 0; m_valid = 0;
      m_run = 0; m_stalls = 0; m_flushes = 0;
    end else if (fl) begin
      m_pc = tgt; m_instr = NOP_INSTR; m_pc4 = 0; m_valid = 0;
      m_run = 0; m_flushes = m_flushes + 1;
    end else begin
      if (ifw) begin
        m_instr = ins; m_pc4 = next_seq; m_valid = 1; m_run = 0;
      end else begin
        m_run = (m_run >= 255) ? 255 : m_run + 1;
        m_stalls = m_stalls + 1;
      end
      if (pcw) m_pc = next_seq;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".instr"}, ifIdInstr, m_instr);
    check({tag, ".pc4"}, ifIdPcPlus4, m_pc4);
    check({tag, ".valid"}, 32'(ifIdValid), 32'(m_valid));
    check({tag, ".stuck"}, 32'(stallStuck), 32'(m_run >= MAX_STALL));
`ifdef FETCH_PERF_CNT_EN
    check({tag, ".stallCount"}, stallCount, m_stalls);
    check({tag, ".flushCount"}, flushCount, m_flushes);
`endif
  endtask

  vec_t vecs[$];

  initial begin
    reset = 1; hzdPcWrite = 0; hzdIfIdWrite = 0; flush = 0;
    branchTarget = 0; instrIn = 0;

    // rst pcw ifw fl tgt instr | pc instr pc4 valid stuck
    vecs.push_back('{1,0,0,0, 32'h0, 32'h0,        32'h0,  NOP_INSTR,    32'h0,  0,0});
    vecs.push_back('{0,1,1,0, 32'h0, 32'h8C080000, 32'h4,  32'h8C080000, 32'h4,  1,0});
    vecs.push_back('{0,1,1,0, 32'h0, 32'h01095020, 32'h8,  32'h01095020, 32'h8,  1,0});
    vecs.push_back('{0,0,0,0, 32'h0, 32'hDEADBEEF, 32'h8,  32'h01095020, 32'h8,  1,0});
    vecs.push_back('{0,1,1,0, 32'h0, 32'h00000000, 32'hC,  32'h00000000, 32'hC,  1,0});
    vecs.push_back('{0,0,0,1, 32'h40,32'h12345678, 32'h40, NOP_INSTR,    32'h0,  0,0});
    vecs.push_back('{0,1,1,0, 32'h0, 32'h11111111, 32'h44, 32'h11111111, 32'h44, 1,0});
    for (int i = 1; i <= 6; i++)
      vecs.push_back('{0,0,0,0, 32'h0, 32'hAAAA0000, 32'h44, 32'h11111111, 32'h44, 1, (i >= MAX_STALL)});
    vecs.push_back('{0,1,1,0, 32'h0, 32'h22222222, 32'h48, 32'h22222222, 32'h48, 1,0});
    vecs.push_back('{0,0,1,1, 32'hFFFFFFFC, 32'h5, 32'hFFFFFFFC, NOP_INSTR, 32'h0, 0,0});
    vecs.push_back('{0,1,1,0, 32'h0, 32'h33333333, 32'h0,  32'h33333333, 32'h0,  1,0});
    vecs.push_back('{1,1,1,1, 32'h80,32'h44444444, RESET_PC, NOP_INSTR,  32'h0,  0,0});
    vecs.push_back('{0,1,0,0, 32'h0, 32'h55555555, 32'h4,  NOP_INSTR,    32'h0,  0,0});

    foreach (vecs[i]) begin
      drive_cycle(vecs[i].rst, vecs[i].pcw, vecs[i].ifw, vecs[i].fl, vecs[i].tgt, vecs[i].instr);
      check($sformatf("vec%0d.pc", i), pc, vecs[i].e_pc);
      check($sformatf("vec%0d.instr", i), ifIdInstr, vecs[i].e_instr);
      check($sformatf("vec%0d.pc4", i), ifIdPcPlus4, vecs[i].e_pc4);
      check($sformatf("vec%0d.valid", i), 32'(ifIdValid), 32'(vecs[i].e_valid));
      check($sformatf("vec%0d.stuck", i), 32'(stallStuck), 32'(vecs[i].e_stuck));
    end

    // Long stall: watchdog counter saturates yet flag stays high, then clears.
    drive_cycle(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 300; i++) begin
      drive_cycle(0, 0, 0, 0, 0, 0);
      model_step(0, 0, 0, 0, 0, 0);
    end
    check_model("sat");
    drive_cycle(0, 1, 1, 0, 0, 32'hCAFEF00D);
    model_step(0, 1, 1, 0, 0, 32'hCAFEF00D);
    check_model("sat_release");

`ifdef FETCH_PERF_CNT_EN
    // Perf counters: 3 stalls + 2 flushes after reset, then reset again.
    drive_cycle(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive_cycle(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) drive_cycle(0, 0, 0, 1, 32'h100, 0);
    check("perf.stallCount", stallCount, 32'd3);
    check("perf.flushCount", flushCount, 32'd2);
    drive_cycle(1, 0, 0, 0, 0, 0);
    check("perf.stallCount_rst", stallCount, 32'd0);
    check("perf.flushCount_rst", flushCount, 32'd0);
`endif

    // Randomized traffic; instruction memory is a hash of the current pc.
    drive_cycle(1, 0, 0, 0, 0, 0);
    model_step(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      logic rst, pcw, ifw, fl;
      logic [31:0] tgt, ins;
      rst = ($urandom_range(0, 99) == 0);
      fl  = ($urandom_range(0, 9) == 0);
      pcw = ($urandom_range(0, 3) != 0);
      ifw = ($urandom_range(0, 2) != 0);
      tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7)) : $urandom;
      ins = (m_pc * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
      drive_cycle(rst, pcw, ifw, fl, tgt, ins);
      model_step(rst, pcw, ifw, fl, tgt, ins);
      check_model($sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
